apb_cmd_master: RTL
===================

# apb_cmd_master

APB requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns each result on a valid/ready response channel. It sits directly upstream of `apb_memory`: it drives that block's `psel`, `penable`, `pwrite`, `paddr` and `pwdata`, and consumes its `prdata`, `pready` and `pslverr`. It adds a bounded wait-state timeout and a configurable read-data sample point, because `apb_memory` registers `prdata` one cycle after the access edge.

## Interface
- `data_width`, default 32: APB and command data width.
- `addr_width`, default 10: APB and command address width.
- `timeout_cycles`, default 16: maximum ACCESS cycles with `pready`=0 before abort. A value of 0 disables the timeout.
- `read_sample_delay`, default 1:
  - 0 samples `prdata` on the completing ACCESS edge.
  - 1 samples it one cycle later. Use 1 with `apb_memory`.

Ports:
- `pclk` in 1: clock; every register updates on its rising edge.
- `preset` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid`&&`cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in `addr_width`: target address.
- `cmd_wdata` in `data_width`: write data; ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid`&&`rsp_ready`.
- `rsp_rdata` out `data_width`: read data. It is 0 for writes and for timeouts.
- `rsp_err` out 1: `pslverr` captured at completion, or 1 on timeout.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out `addr_width`: APB address.
- `pwdata` out `data_width`: APB write data.
- `prdata` in `data_width`: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.

## Operation
States are IDLE, SETUP, ACCESS, CAPTURE and RESP.

- **IDLE**
  - `cmd_ready`=1. It is forced to 0 while `preset`=1.
  - On accept: latch `cmd_write`, `cmd_addr` and `cmd_wdata` into `pwrite`, `paddr` and `pwdata`; clear the wait counter; go to SETUP.
- **SETUP**
  - `psel`=1, `penable`=0.
  - Next state is always ACCESS.
- **ACCESS**
  - `psel`=1, `penable`=1.
  - When `pready`=1, the access completes:
    - `rsp_err` <= `pslverr`.
    - Write: `rsp_rdata` <= 0, then go to RESP.
    - Read with `read_sample_delay`=0: `rsp_rdata` <= `prdata`, then go to RESP.
    - Read with `read_sample_delay`=1: go to CAPTURE.
  - When `pready`=0:
    - The wait counter increments.
    - When `timeout_cycles`≠0 and the counter reaches `timeout_cycles`-1, abort: `rsp_err` <= 1, `rsp_rdata` <= 0, go to RESP.
    - Completion takes priority over timeout in the same cycle.
- **CAPTURE**
  - `psel`=0, `penable`=0.
  - At the end of the cycle, `rsp_rdata` <= `prdata`; go to RESP.
- **RESP**
  - `rsp_valid`=1, `psel`=0, `penable`=0.
  - `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`=1, go to IDLE. `cmd_ready` is not asserted in the same cycle.
- Register updates:
  - `paddr`, `pwdata` and `pwrite` change only on command accept. They hold their last value otherwise.
  - The wait counter is `$clog2(timeout_cycles)+1` bits wide and never wraps.
  - Exactly one transfer is in flight; there is no command buffering.

## Timing
- Reset:
  - `preset`=1 at a rising edge forces state IDLE.
  - All outputs are 0 while reset is asserted, including `cmd_ready`, which is forced low.
  - Reset applied mid-transfer (SETUP, ACCESS, CAPTURE or RESP) drops `psel` and `penable` from the next cycle. The response is discarded.
  - After reset, `cmd_ready`=1 in the first cycle with `preset`=0.
- Latency from the accept edge to `rsp_valid` visible, with zero wait states:
  - Write: 2 cycles.
  - Read, `read_sample_delay`=0: 2 cycles.
  - Read, `read_sample_delay`=1: 3 cycles.
  - Each `pready`=0 cycle adds 1.
- Throughput with `rsp_ready` tied high:
  - One write per 4 cycles (IDLE, SETUP, ACCESS, RESP).
  - One read per 5 cycles with `read_sample_delay`=1.
- APB rule: SETUP always lasts exactly 1 cycle, and `penable` never rises without a preceding SETUP cycle.
- Timeout: with `timeout_cycles`=N, ACCESS lasts at most N cycles.

## Test plan
- **Write then read against `apb_memory`** (`read_sample_delay`=1): write addr 0x003 data 0xDEADBEEF, then read addr 0x003. Required: `rsp_rdata`=0xDEADBEEF, `rsp_err`=0; `rsp_valid` rises 2 cycles after the write accept and 3 cycles after the read accept.
- **Wait states:** a slave model holds `pready`=0 for 3 ACCESS cycles during a read of 0x55AA55AA with `read_sample_delay`=0. Required: ACCESS lasts 4 cycles, `paddr` is stable throughout, `rsp_rdata`=0x55AA55AA, `rsp_err`=0.
- **Timeout:** `timeout_cycles`=4 with `pready` stuck low. Required: ACCESS lasts exactly 4 cycles, then `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0; `psel`=0 from the RESP cycle.
- **Slave error and backpressure:** `pslverr`=1 on completion with `rsp_ready`=0 for 5 cycles. Required: `rsp_valid`, `rsp_err`=1 and `rsp_rdata` are held for all 5 cycles; `cmd_ready`=0 until the cycle after `rsp_ready`=1.
- **Reset mid-ACCESS:** assert `preset` for 1 cycle during ACCESS. Required: the next cycle has `psel`=`penable`=`rsp_valid`=0, `paddr`=0 and `pwdata`=0; `cmd_ready`=1 in the first cycle after release; no response is emitted for the aborted command.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Bundles the command, response and APB signals of apb_cmd_master.
// The master modport is the requester's view; slave is the view of whatever drives it and models the APB target.
interface apb_cmd_master_if #(
  parameter int data_width = 32,
  parameter int addr_width = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [addr_width-1:0] cmd_addr;
  logic [data_width-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [data_width-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [addr_width-1:0] paddr;
  logic [data_width-1:0] pwdata;
  logic [data_width-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer,
// answered on a valid/ready response channel, with wait-state timeout and optional delayed read sampling.
module apb_cmd_master #(
  parameter int data_width        = 32,
  parameter int addr_width        = 10,
  parameter int timeout_cycles    = 16,
  parameter int read_sample_delay = 1
) (
  input  logic              pclk,
  input  logic              preset,
  apb_cmd_master_if.master  bus
);

  localparam int CntW = $clog2(timeout_cycles) + 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'((timeout_cycles == 0) ? 0 : timeout_cycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    CAPTURE,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  pwrite_q, pwrite_d;
  logic [addr_width-1:0] paddr_q, paddr_d;
  logic [data_width-1:0] pwdata_q, pwdata_d;
  logic [data_width-1:0] rspRdata_q, rspRdata_d;
  logic                  rspErr_q, rspErr_d;
  logic [CntW-1:0]       waitCnt_q, waitCnt_d;
  logic                  cmdReady;

  assign cmdReady = (state_q == IDLE) && !preset;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= IDLE;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
      waitCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
      waitCnt_q  <= waitCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    waitCnt_d  = waitCnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmdReady) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          waitCnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // Completion wins over timeout when both happen in the same cycle.
        if (bus.pready) begin
          rspErr_d = bus.pslverr;
          if (pwrite_q) begin
            rspRdata_d = '0;
            state_d    = RESP;
          end else if (read_sample_delay == 0) begin
            rspRdata_d = bus.prdata;
            state_d    = RESP;
          end else begin
            state_d    = CAPTURE;
          end
        end else begin
          if (waitCnt_q != {CntW{1'b1}}) waitCnt_d = waitCnt_q + CntW'(1);
          if ((timeout_cycles != 0) && (waitCnt_q == CntLast)) begin
            rspErr_d   = 1'b1;
            rspRdata_d = '0;
            state_d    = RESP;
          end
        end
      end
      CAPTURE: begin
        rspRdata_d = bus.prdata;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = cmdReady;
  assign bus.psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable   = (state_q == ACCESS);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rspRdata_q;
  assign bus.rsp_err   = rspErr_q;

endmodule
